alu_pipe: RTL
=============

ALU_PIPE -- requirements
Module: alu_pipe

Interface
REQ-001 Parameter WIDTH, 16, datapath width in bits (>= 8).
REQ-002 Parameter IMM_W, 5, immediate field width; ir width is IMM_W+1.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  operation request valid.
REQ-006 in_ready  output  1  block accepts request this cycle.
REQ-007 op  input  3  opcode: 000 PASS, 001 ADD, 010 AND, 011 NOT, 100 XOR, 101 SHL, 110 SRA, 111 MUL.
REQ-008 ra  input  WIDTH  operand A.
REQ-009 rb  input  WIDTH  operand B (register source).
REQ-010 ir  input  IMM_W+1  ir[IMM_W]=1 selects sign-extended ir[IMM_W-1:0] as B, else rb.
REQ-011 out_valid  output  1  result valid.
REQ-012 out_ready  input  1  consumer accepts result.
REQ-013 result  output  WIDTH  registered result.
REQ-014 nzp  output  3  one-hot condition code of result {N,Z,P}.
REQ-015 v  output  1  signed overflow of ADD; 0 for all other ops.

Function
REQ-016 Transfer in = in_valid & in_ready; transfer out = out_valid & out_ready.
REQ-017 FSM states: IDLE (output empty), MUL (iterating), HOLD (output full).
REQ-018 in_ready SHALL be 1 in IDLE, out_ready in HOLD, 0 in MUL.
REQ-019 Non-MUL op accepted: result, nzp, v registered on next edge; state -> HOLD; latency 1 cycle.
REQ-020 MUL accepted: state -> MUL; WIDTH shift-add iterations, one per cycle; then result loaded, state -> HOLD; out_valid asserted WIDTH+1 cycles after acceptance.
REQ-021 MUL result = low WIDTH bits of unsigned ra*B; v=0.
REQ-022 ADD wraps modulo 2^WIDTH; v=1 when ra and B share sign and sum sign differs.
REQ-023 PASS = ra; NOT = ~ra (B ignored); AND/XOR bitwise with B.
REQ-024 SHL/SRA shift ra by B[$clog2(WIDTH)-1:0]; SRA replicates ra MSB.
REQ-025 nzp: 100 if result MSB=1, 010 if result=0, 001 otherwise; exactly one bit set always.
REQ-026 HOLD with out_ready=0: result, nzp, v, out_valid SHALL hold stable.
REQ-027 HOLD with transfer out and transfer in same cycle: new op accepted, back-to-back throughput 1/cycle for non-MUL ops.
REQ-028 HOLD with transfer out, no transfer in: state -> IDLE, out_valid -> 0; result/nzp retain last value.
REQ-029 in_valid while in_ready=0 SHALL have no effect; operands sampled only at transfer in.
REQ-030 out_valid=1 exactly in HOLD.

Reset
REQ-031 reset SHALL force state IDLE, out_valid 0, result 0, nzp 010, v 0, multiplier registers 0, overriding all other inputs incl. mid-MUL (operation discarded).
REQ-032 in_ready SHALL be 1 on the first cycle after reset deasserts.

Structure
REQ-033 Package alu_pkg SHALL hold opcode constants, FSM state enum, NZP_RESET=3'b010.
REQ-034 Sub-module alu_mul_iter (start, busy, done, WIDTH-parameterised shift-add multiplier) SHALL implement MUL.
REQ-035 Immediate sign-extension and B-mux SHALL be combinational inside alu_pipe.

Verification (WIDTH=16, IMM_W=5)
REQ-036 ADD ra=0x0005, ir=6'b1_11111 -> result 0x0004, nzp 001, v 0, out_valid 1 cycle after accept.
REQ-037 ADD ra=0x7FFF, rb=0x0001, ir[5]=0 -> result 0x8000, nzp 100, v 1; NOT ra=0xFFFF -> 0x0000, nzp 010.
REQ-038 MUL ra=0x0003, rb=0xFFFE -> result 0xFFFA, nzp 100; in_ready 0 for 16 cycles, out_valid at cycle 17.
REQ-039 out_ready low 3 cycles in HOLD -> result stable, in_ready 0; then 4 back-to-back AND ops with out_ready=1 -> 4 results on 4 consecutive cycles.
REQ-040 reset asserted 5 cycles into MUL -> next cycle out_valid 0, nzp 010, result 0; in_ready 1 after release, no stale result emitted.
REQ-041 SRA ra=0x8000, rb=0x0013 (amount 3) -> 0xF000; SHL ra=0x0001, rb=0x000F -> 0x8000.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared opcode encoding, FSM state type and condition-code helpers for the
// pipelined ALU.
package alu_pkg;

    typedef enum logic [2:0] {
        OP_PASS = 3'b000,
        OP_ADD  = 3'b001,
        OP_AND  = 3'b010,
        OP_NOT  = 3'b011,
        OP_XOR  = 3'b100,
        OP_SHL  = 3'b101,
        OP_SRA  = 3'b110,
        OP_MUL  = 3'b111
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_MUL  = 2'b01,
        ST_HOLD = 2'b10
    } state_e;

    localparam logic [2:0] NZP_RESET = 3'b010;

    // One-hot {N,Z,P}; width-independent so callers pass only MSB and zero flag.
    function automatic logic [2:0] nzp_of(input logic msb, input logic is_zero);
        if (msb) begin
            return 3'b100;
        end else if (is_zero) begin
            return 3'b010;
        end
        return 3'b001;
    endfunction

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative shift-add multiplier: one partial product per cycle, WIDTH cycles,
// low WIDTH bits of the unsigned product presented alongside done.
module alu_mul_iter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] product
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic [WIDTH-1:0] acc_next;

    always_comb begin
        // NOTE: every output gets a default first so no path leaves a latch.
        a_d      = a_q;
        b_d      = b_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        busy_d   = busy_q;
        acc_next = acc_q + (b_q[0] ? a_q : '0);
        done     = busy_q && (cnt_q == CNT_W'(WIDTH - 1));

        if (start) begin
            a_d    = a;
            b_d    = b;
            acc_d  = '0;
            cnt_d  = '0;
            busy_d = 1'b1;
        end else if (busy_q) begin
            acc_d = acc_next;
            a_d   = a_q << 1;
            b_d   = b_q >> 1;
            cnt_d = cnt_q + CNT_W'(1);
            if (done) begin
                busy_d = 1'b0;
            end
        end
    end

    // The final partial product is folded in combinationally so the result
    // is ready on the same edge as the last iteration.
    assign product = acc_next;
    assign busy    = busy_q;

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments only.
        if (reset) begin
            a_q    <= '0;
            b_q    <= '0;
            acc_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
        end else begin
            a_q    <= a_d;
            b_q    <= b_d;
            acc_q  <= acc_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
        end
    end

endmodule

// File: rtl/alu_pipe.sv
// Single-slot ALU with valid/ready handshakes: one-cycle ops complete on the
// accepting edge, MUL is handed to the iterative multiplier.
module alu_pipe
    import alu_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int IMM_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] ra,
    input  logic [WIDTH-1:0] rb,
    input  logic [IMM_W:0]   ir,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [2:0]       nzp,
    output logic             v
);

    localparam int SH_W = $clog2(WIDTH);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [2:0]       nzp_q, nzp_d;
    logic             v_q, v_d;

    logic [WIDTH-1:0] b_sel;
    logic [SH_W-1:0]  sh_amt;
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] alu_res;
    logic             alu_v;
    logic             transfer_in;
    logic             mul_start, mul_busy, mul_done;
    logic [WIDTH-1:0] mul_product;

    assign b_sel  = ir[IMM_W] ? {{(WIDTH - IMM_W){ir[IMM_W-1]}}, ir[IMM_W-1:0]} : rb;
    assign sh_amt = b_sel[SH_W-1:0];
    assign sum    = ra + b_sel;

    always_comb begin
        alu_res = '0;
        alu_v   = 1'b0;
        case (op_e'(op))
            OP_PASS: alu_res = ra;
            OP_ADD: begin
                alu_res = sum;
                alu_v   = (ra[WIDTH-1] == b_sel[WIDTH-1]) && (sum[WIDTH-1] != ra[WIDTH-1]);
            end
            OP_AND:  alu_res = ra & b_sel;
            OP_NOT:  alu_res = ~ra;
            OP_XOR:  alu_res = ra ^ b_sel;
            OP_SHL:  alu_res = ra << sh_amt;
            OP_SRA:  alu_res = $unsigned($signed(ra) >>> sh_amt);
            default: alu_res = '0;
        endcase
    end

    // Downstream ready passes straight through in HOLD for 1/cycle throughput.
    always_comb begin
        case (state_q)
            ST_IDLE: in_ready = 1'b1;
            ST_HOLD: in_ready = out_ready;
            default: in_ready = 1'b0;
        endcase
    end

    assign transfer_in = in_valid && in_ready;

    always_comb begin
        state_d   = state_q;
        result_d  = result_q;
        nzp_d     = nzp_q;
        v_d       = v_q;
        mul_start = 1'b0;

        case (state_q)
            ST_IDLE, ST_HOLD: begin
                if (transfer_in) begin
                    if (op_e'(op) == OP_MUL) begin
                        mul_start = 1'b1;
                        state_d   = ST_MUL;
                    end else begin
                        result_d = alu_res;
                        nzp_d    = nzp_of(alu_res[WIDTH-1], alu_res == '0);
                        v_d      = alu_v;
                        state_d  = ST_HOLD;
                    end
                end else if (state_q == ST_HOLD && out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            ST_MUL: begin
                if (mul_done) begin
                    result_d = mul_product;
                    nzp_d    = nzp_of(mul_product[WIDTH-1], mul_product == '0);
                    v_d      = 1'b0;
                    state_d  = ST_HOLD;
                end else if (!mul_busy) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            result_q <= '0;
            nzp_q    <= NZP_RESET;
            v_q      <= 1'b0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            nzp_q    <= nzp_d;
            v_q      <= v_d;
        end
    end

    assign out_valid = (state_q == ST_HOLD);
    assign result    = result_q;
    assign nzp       = nzp_q;
    assign v         = v_q;

    alu_mul_iter #(
        .WIDTH(WIDTH)
    ) u_mul (
        .clk    (clk),
        .reset  (reset),
        .start  (mul_start),
        .a      (ra),
        .b      (b_sel),
        .busy   (mul_busy),
        .done   (mul_done),
        .product(mul_product)
    );

endmodule
